// File: rtl/axil_gpio_bank.sv
// AXI4-Lite GPIO bank: NUM_OUT strobed R/W output words, NUM_IN sampled read-only words.
// Write commits 1 cycle after both AW/W held (B in cycle 2); read data 1 cycle after AR; B/R hold until ready.
module axil_gpio_bank #(
    parameter int                       NUM_OUT    = 4,
    parameter int                       NUM_IN     = 2,
    parameter int                       ADDR_WIDTH = 8,
    parameter logic [NUM_OUT*32-1:0]    OUT_RESET  = '0,
    parameter int                       IN_W       = (NUM_IN > 0) ? NUM_IN*32 : 32
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [ADDR_WIDTH-1:0]       s_axil_awaddr,
    input  logic                        s_axil_awvalid,
    output logic                        s_axil_awready,
    input  logic [31:0]                 s_axil_wdata,
    input  logic [3:0]                  s_axil_wstrb,
    input  logic                        s_axil_wvalid,
    output logic                        s_axil_wready,
    output logic [1:0]                  s_axil_bresp,
    output logic                        s_axil_bvalid,
    input  logic                        s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]       s_axil_araddr,
    input  logic                        s_axil_arvalid,
    output logic                        s_axil_arready,
    output logic [31:0]                 s_axil_rdata,
    output logic [1:0]                  s_axil_rresp,
    output logic                        s_axil_rvalid,
    input  logic                        s_axil_rready,
    output logic [NUM_OUT*32-1:0]       gpio_out,
    output logic [NUM_OUT-1:0]          gpio_upd,
    input  logic [IN_W-1:0]             gpio_in
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W:0] N_OUT = (IDX_W+1)'(NUM_OUT);
    localparam logic [IDX_W:0] N_TOT = (IDX_W+1)'(NUM_OUT + NUM_IN);

    localparam logic [1:0] RESP_OK     = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic                   live_q;
    logic                   aw_full_q, aw_full_d;
    logic [IDX_W-1:0]       aw_idx_q, aw_idx_d;
    logic                   w_full_q, w_full_d;
    logic [31:0]            w_dat_q, w_dat_d;
    logic [3:0]             w_strb_q, w_strb_d;
    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;
    logic                   rvalid_q, rvalid_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;
    logic [NUM_OUT*32-1:0]  out_q, out_d;
    logic [NUM_OUT-1:0]     upd_q, upd_d;
    logic [IN_W-1:0]        in_q;

    logic                   aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]       ar_idx;
    logic                   aw_is_out, aw_is_in, ar_is_out, ar_is_in;

    // Byte offset within a word carries no meaning here.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    assign s_axil_awready = live_q && !aw_full_q;
    assign s_axil_wready  = live_q && !w_full_q;
    assign s_axil_arready = live_q && !rvalid_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign gpio_out       = out_q;
    assign gpio_upd       = upd_q;

    assign aw_hs  = s_axil_awvalid && s_axil_awready;
    assign w_hs   = s_axil_wvalid  && s_axil_wready;
    assign ar_hs  = s_axil_arvalid && s_axil_arready;
    assign commit = aw_full_q && w_full_q && !bvalid_q;
    assign ar_idx = s_axil_araddr[ADDR_WIDTH-1:2];

    assign aw_is_out = ({1'b0, aw_idx_q} < N_OUT);
    assign aw_is_in  = !aw_is_out && ({1'b0, aw_idx_q} < N_TOT);
    assign ar_is_out = ({1'b0, ar_idx} < N_OUT);
    assign ar_is_in  = !ar_is_out && ({1'b0, ar_idx} < N_TOT);

    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_dat_d   = w_dat_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        out_d     = out_q;
        upd_d     = '0;

        if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end

        // Commit only ever fires with both holders full, so it never races a new handshake.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (aw_is_out) begin
                bresp_d = RESP_OK;
                for (int k = 0; k < NUM_OUT; k++) begin
                    if (aw_idx_q == IDX_W'(k)) begin
                        upd_d[k] = 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (w_strb_q[b]) begin
                                out_d[32*k+8*b +: 8] = w_dat_q[8*b +: 8];
                            end
                        end
                    end
                end
            end else if (aw_is_in) begin
                bresp_d = RESP_SLVERR;
            end else begin
                bresp_d = RESP_DECERR;
            end
        end

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axil_awaddr[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_dat_d  = s_axil_wdata;
            w_strb_d = s_axil_wstrb;
        end
    end

    // Reads sample out_q before any same-cycle commit lands.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_DECERR;
            if (ar_is_out) begin
                rresp_d = RESP_OK;
                for (int k = 0; k < NUM_OUT; k++) begin
                    if (ar_idx == IDX_W'(k)) begin
                        rdata_d = out_q[32*k +: 32];
                    end
                end
            end else if (ar_is_in) begin
                rresp_d = RESP_OK;
                for (int j = 0; j < NUM_IN; j++) begin
                    if (ar_idx == IDX_W'(NUM_OUT + j)) begin
                        rdata_d = in_q[32*j +: 32];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            live_q    <= 1'b0;
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_dat_q   <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OK;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OK;
            out_q     <= OUT_RESET;
            upd_q     <= '0;
            in_q      <= '0;
        end else begin
            live_q    <= 1'b1;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_dat_q   <= w_dat_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            out_q     <= out_d;
            upd_q     <= upd_d;
            in_q      <= gpio_in;
        end
    end

endmodule

// File: tb/tb_axil_gpio_bank.sv
// Scoreboarded bench for axil_gpio_bank: B/R responses queued at issue, popped on handshake.
module tb_axil_gpio_bank;

    localparam int NO = 4;
    localparam int NI = 2;
    localparam int AW = 8;
    localparam logic [NO*32-1:0] RST_IMG = 128'h1;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [AW-1:0]     awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b1;
    logic [AW-1:0]     araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b1;
    logic [NO*32-1:0]  gpio_out;
    logic [NO-1:0]     gpio_upd;
    logic [NI*32-1:0]  gpio_in = '0;

    int n_chk = 0;
    int n_err = 0;
    logic [1:0]  b_q[$];
    logic [33:0] r_q[$];
    logic [NO*32-1:0] mdl;

    always #5 clk = ~clk;

    axil_gpio_bank #(
        .NUM_OUT(NO), .NUM_IN(NI), .ADDR_WIDTH(AW), .OUT_RESET(RST_IMG)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .gpio_out(gpio_out), .gpio_upd(gpio_upd), .gpio_in(gpio_in)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && bvalid && bready) begin
            if (b_q.size() == 0) check("b_unexpected", 1, 0);
            else check("bresp", bresp, b_q.pop_front());
        end
        if (resetn && rvalid && rready) begin
            if (r_q.size() == 0) check("r_unexpected", 1, 0);
            else check("rdata_rresp", {rresp, rdata}, r_q.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the later of the AW/W handshakes.
    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_resp);
        bit aw_done = 0, w_done = 0, aw_now, w_now;
        b_q.push_back(exp_resp);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 50 && !(aw_done && w_done); i++) begin
            @(negedge clk);
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            cyc();
            if (aw_now) begin aw_done = 1; awvalid = 1'b0; end
            if (w_now)  begin w_done = 1;  wvalid = 1'b0; end
        end
        if (!(aw_done && w_done)) check("wr_timeout", 0, 1);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
        bit done = 0, now;
        r_q.push_back({exp_r, exp_d});
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            now = arvalid && arready;
            cyc();
            if (now) begin done = 1; arvalid = 1'b0; end
        end
        if (!done) check("rd_timeout", 0, 1);
        arvalid = 1'b0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!rvalid) done = 1;
        end
        if (!done) check("rvalid_stuck", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        gpio_in = {32'h1234_5678, 32'hA5A5_A5A5};
        mdl = RST_IMG;

        // Reset state and ready release
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out", gpio_out, RST_IMG);
        check("rst_upd", gpio_upd, 0);
        check("rst_rdy", {awready, wready, arready}, 3'b000);
        check("rst_vld", {bvalid, rvalid}, 2'b00);
        check("rst_resp", {bresp, rresp, rdata}, 0);
        cyc();
        resetn = 1'b1;
        @(negedge clk);
        check("rdy_pre", {awready, wready, arready}, 3'b000);
        @(negedge clk);
        check("rdy_post", {awready, wready, arready}, 3'b111);

        // Simultaneous AW/W, latency and pulse
        cyc();
        do_write(8'h04, 32'hDEAD_BEEF, 4'hF, 2'b00);
        mdl[63:32] = 32'hDEAD_BEEF;
        @(negedge clk);
        check("c1_rdy", {awready, wready}, 2'b00);
        check("c1_bvld", bvalid, 0);
        check("c1_upd", gpio_upd, 0);
        @(negedge clk);
        check("c2_bvld", bvalid, 1);
        check("c2_out", gpio_out, mdl);
        check("c2_upd", gpio_upd, 4'b0010);
        check("c2_rdy", {awready, wready}, 2'b11);
        @(negedge clk);
        check("c3_upd", gpio_upd, 0);
        check("c3_bvld", bvalid, 0);

        // Partial strobe
        cyc();
        do_write(8'h04, 32'h1122_3344, 4'b0101, 2'b00);
        mdl[63:32] = 32'hDE22_BE44;
        repeat (2) @(negedge clk);
        check("strb_out", gpio_out, mdl);
        cyc();
        do_read(8'h04, 32'hDE22_BE44, 2'b00);

        // W three cycles ahead of AW
        cyc();
        b_q.push_back(2'b00);
        wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        check("early_w_rdy", wready, 1);
        cyc();
        wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("w_held_rdy", wready, 0);
            check("w_held_out", gpio_out, mdl);
            cyc();
        end
        awaddr = 8'h00; awvalid = 1'b1;
        @(negedge clk);
        check("late_aw_rdy", {awready, wready}, 2'b10);
        cyc();
        awvalid = 1'b0;
        @(negedge clk);
        check("late_pre", gpio_out, mdl);
        mdl[31:0] = 32'h5;
        @(negedge clk);
        check("late_out", gpio_out, mdl);
        check("late_upd", gpio_upd, 4'b0001);

        // Error responses and input reads
        cyc();
        do_write(8'h10, 32'hFFFF_FFFF, 4'hF, 2'b10);
        repeat (2) @(negedge clk);
        check("slverr_out", gpio_out, mdl);
        check("slverr_upd", gpio_upd, 0);
        cyc();
        do_write(8'h40, 32'hFFFF_FFFF, 4'hF, 2'b11);
        repeat (2) @(negedge clk);
        check("decerr_out", gpio_out, mdl);
        cyc();
        do_read(8'h10, 32'hA5A5_A5A5, 2'b00);
        cyc();
        do_read(8'h17, 32'h1234_5678, 2'b00);
        cyc();
        do_read(8'h40, 32'h0, 2'b11);
        cyc();
        do_read(8'h00, 32'h5, 2'b00);

        // B back-pressure with a second write queued
        cyc();
        bready = 1'b0;
        do_write(8'h08, 32'hCAFE_F00D, 4'hF, 2'b00);
        do_write(8'h0C, 32'h0BAD_F00D, 4'hF, 2'b00);
        mdl[95:64] = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_bvld", bvalid, 1);
            check("bp_rdy", awready, 0);
            check("bp_out", gpio_out, mdl);
            cyc();
        end
        bready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_gap_bvld", bvalid, 0);
        check("bp_gap_out", gpio_out, mdl);
        mdl[127:96] = 32'h0BAD_F00D;
        @(negedge clk);
        check("bp_commit_out", gpio_out, mdl);
        check("bp_commit_upd", gpio_upd, 4'b1000);

        // Reset while a write is pending behind back-pressure
        cyc();
        bready = 1'b0;
        do_write(8'h00, 32'h77, 4'hF, 2'b00);
        do_write(8'h04, 32'h88, 4'hF, 2'b00);
        cyc();
        resetn = 1'b0;
        cyc();
        @(negedge clk);
        check("mid_rst_out", gpio_out, RST_IMG);
        check("mid_rst_vld", {bvalid, awready, arready}, 3'b000);
        cyc();
        resetn = 1'b1;
        b_q.delete();
        bready = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_bvld", bvalid, 0);
        check("post_rst_out", gpio_out, RST_IMG);
        check("post_rst_upd", gpio_upd, 0);
        check("post_rst_rdy", {awready, wready, arready}, 3'b111);

        check("sb_b_empty", b_q.size(), 0);
        check("sb_r_empty", r_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axil_gpio_bank.md
# axil_gpio_bank

Parametrised AXI4-Lite GPIO register bank that replaces the single write-only GPIO word in the verification top. It provides NUM_OUT read/write output registers with byte strobes, NUM_IN read-only sampled input words, full read channel support, error responses, and a per-register update pulse. It sits on an interconnect master port; bit 0 of output register 0 typically drives the CPU `resetn`.

## Interface
- `NUM_OUT`, 4: output registers (1–16).
- `NUM_IN`, 2: input words (0–16).
- `ADDR_WIDTH`, 8: address bits decoded; must cover (NUM_OUT+NUM_IN)*4 bytes.
- `OUT_RESET`, 0: NUM_OUT*32-bit reset image; word k is bits [32k+31:32k].

Ports:
- `clk` in 1: the only clock; everything is on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `s_axil_awaddr` in ADDR_WIDTH, `s_axil_awvalid` in 1, `s_axil_awready` out 1: write address.
- `s_axil_wdata` in 32, `s_axil_wstrb` in 4, `s_axil_wvalid` in 1, `s_axil_wready` out 1: write data.
- `s_axil_bresp` out 2, `s_axil_bvalid` out 1, `s_axil_bready` in 1: write response.
- `s_axil_araddr` in ADDR_WIDTH, `s_axil_arvalid` in 1, `s_axil_arready` out 1: read address.
- `s_axil_rdata` out 32, `s_axil_rresp` out 2, `s_axil_rvalid` out 1, `s_axil_rready` in 1: read data.
- `gpio_out` out NUM_OUT*32: output register contents.
- `gpio_upd` out NUM_OUT: one-cycle pulse per committed write.
- `gpio_in` in NUM_IN*32: external inputs.

## Operation
- Word index is `addr[ADDR_WIDTH-1:2]`. `addr[1:0]` is ignored.
  - Index 0..NUM_OUT-1: output register, read/write.
  - Index NUM_OUT..NUM_OUT+NUM_IN-1: input word, read-only.
  - Higher indices: unmapped.
- `gpio_in` is registered every cycle into `in_q`. Reads of input words return `in_q`.
- Write path: AW and W are accepted independently into one holding register each.
  - `awready` is 1 iff the AW holding register is empty and the block is out of reset. `wready` follows the same rule for W.
  - A commit fires in a cycle where both holding registers are full and `bvalid`=0.
  - On commit to an output register, only bytes whose `wstrb` bit is 1 are updated. `gpio_upd[k]` pulses and `bresp`=00, even if `wstrb`=0.
  - On commit to an input word: no update, no pulse, `bresp`=10 (SLVERR).
  - On commit to an unmapped index: no update, no pulse, `bresp`=11 (DECERR).
  - The commit empties both holding registers and sets `bvalid`. `bvalid` holds until `bready`.
- Read path: `arready` = !`rvalid`, out of reset.
  - On an AR handshake, `rdata`/`rresp` are registered and `rvalid` is set. They hold until `rready`.
  - Output register read: contents, `rresp`=00. Input word read: `in_q`, `rresp`=00. Unmapped read: `rdata`=0, `rresp`=11.
- Read and write channels are independent.

## Timing
- Reset (`resetn`=0 at an edge):
  - `gpio_out` = OUT_RESET; `gpio_upd`=0; `in_q`=0.
  - All ready and valid outputs = 0; `bresp`=`rresp`=00; `rdata`=0.
  - Holding registers are emptied. In-flight transactions are discarded with no register update and no response.
  - `awready`, `wready` and `arready` become 1 at the first edge with `resetn`=1.
- Write latency, with AW and W handshaking in cycle 0:
  - Holding registers are full in cycle 1; commit occurs at the end of cycle 1.
  - In cycle 2: `bvalid`=1, `gpio_out` shows the new value, `gpio_upd` is high for cycle 2 only.
  - `awready`/`wready` are 0 in cycle 1 and return to 1 in cycle 2.
- Staggered AW/W: the commit fires the cycle after the later handshake completes.
- Back-pressure: while `bvalid`=1 and `bready`=0, a new AW and W may each be accepted and held. The commit waits until the cycle after `bvalid` clears.
- Read latency: AR handshake in cycle 0 gives `rvalid`=1 in cycle 1. `arready`=0 while `rvalid`=1. With `rready` held high, one read completes every 2 cycles.
- Same-cycle write commit and AR to the same register: the read returns the pre-write value.
- Input word reads reflect `gpio_in` one cycle earlier than the AR handshake cycle.

## Test plan
- Reset with OUT_RESET word0=0x0000_0001 → `gpio_out[31:0]`=1 and all ready/valid outputs = 0 during reset; readies = 1 one cycle after `resetn` rises.
- Simultaneous AW=0x04, W=0xDEADBEEF, `wstrb`=0xF → `bvalid` 2 cycles later, `bresp`=00, `gpio_out[63:32]`=0xDEADBEEF, `gpio_upd`=4'b0010 for one cycle.
- Partial strobe: reg1=0xDEADBEEF, then write 0x11223344 with `wstrb`=4'b0101 → reg1=0xDE22BE44; a subsequent read returns 0xDE22BE44 with `rresp`=00.
- W issued 3 cycles before AW to 0x00 with data 0x5 → W held (`wready`=0) for those cycles; commit the cycle after the AW handshake; `gpio_out[31:0]`=5.
- Write to input word 0x10 (NUM_OUT=4) → `bresp`=10, registers unchanged. Read 0x10 with `gpio_in[31:0]`=0xA5A5A5A5 → 0xA5A5A5A5. Read 0x40 → `rdata`=0, `rresp`=11.
- `bready` held 0 for 5 cycles with a second write queued → no second commit until `bvalid` clears. Assert `resetn`=0 mid-wait → pending write discarded, registers = OUT_RESET.
